// File: rtl/cycle_seq.sv
// cycle_seq: washer program sequencer (wash, rinse, spin)
// drives fill, motor and drain from a unit tick strobe
module cycle_seq #(
  parameter int WASH_U = 12,
  parameter int RNS_U  = 6,
  parameter int SPN_U  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pau,
  input  logic       tick,
  input  logic [2:0] mode,
  input  logic [5:0] u_wat,
  output logic       busy,
  output logic [2:0] ph,
  output logic       fl,
  output logic       mot,
  output logic       dr,
  output logic [8:0] u_rem,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE, FILL, AGIT, DRAIN, SPIN, ABRT
  } st_t;

  localparam logic [2:0] PH_W = 3'b100;
  localparam logic [2:0] PH_R = 3'b010;
  localparam logic [2:0] PH_S = 3'b001;

  st_t        st;
  logic [2:0] ph_r;
  logic [5:0] lvl;
  logic [5:0] cnt;
  logic [5:0] wat_r;
  logic       rn_en;
  logic       sp_en;
  logic       frz;

  logic       ct;
  logic [5:0] cnt_nx;
  logic [5:0] lim;
  logic [8:0] w2;
  logic [8:0] tot;

  assign ct     = tick && !pau;
  assign cnt_nx = cnt + 6'd1;
  assign lim    = ph_r[2] ? 6'(WASH_U) : 6'(RNS_U);
  assign w2     = {2'b00, u_wat, 1'b0};

  always_comb begin
    tot = '0;
    if (mode[2]) tot = tot + w2 + 9'(WASH_U);
    if (mode[1]) tot = tot + w2 + 9'(RNS_U);
    if (mode[0]) tot = tot + 9'(SPN_U);
  end

  // actuators drop the cycle after pau is seen
  assign busy = (st != IDLE);
  assign ph   = ph_r;
  assign fl   = (st == FILL) && !frz;
  assign mot  = ((st == AGIT) || (st == SPIN)) && !frz;
  assign dr   = ((st == DRAIN) || (st == ABRT)) && !frz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= IDLE;
      ph_r  <= '0;
      lvl   <= '0;
      cnt   <= '0;
      wat_r <= '0;
      rn_en <= 1'b0;
      sp_en <= 1'b0;
      u_rem <= '0;
      done  <= 1'b0;
      frz   <= 1'b0;
    end else begin
      done <= 1'b0;
      frz  <= pau;
      case (st)
        IDLE: begin
          if (start && !abort &&
              (mode != 3'b000) && (u_wat != 6'd0)) begin
            wat_r <= u_wat;
            rn_en <= mode[1];
            sp_en <= mode[0];
            u_rem <= tot;
            lvl   <= '0;
            cnt   <= '0;
            if (mode[2]) begin
              st   <= FILL;
              ph_r <= PH_W;
            end else if (mode[1]) begin
              st   <= FILL;
              ph_r <= PH_R;
            end else begin
              st   <= SPIN;
              ph_r <= PH_S;
            end
          end
        end
        ABRT: begin
          if (ct) begin
            lvl <= lvl - 6'd1;
            if (lvl == 6'd1) st <= IDLE;
          end
        end
        default: begin
          if (abort) begin
            u_rem <= '0;
            ph_r  <= '0;
            cnt   <= '0;
            st    <= (lvl != 6'd0) ? ABRT : IDLE;
          end else if (ct) begin
            u_rem <= u_rem - 9'd1;
            case (st)
              FILL: begin
                lvl <= lvl + 6'd1;
                if (lvl + 6'd1 == wat_r) begin
                  st  <= AGIT;
                  cnt <= '0;
                end
              end
              AGIT: begin
                cnt <= cnt_nx;
                if (cnt_nx == lim) st <= DRAIN;
              end
              DRAIN: begin
                lvl <= lvl - 6'd1;
                if (lvl == 6'd1) begin
                  if (ph_r[2] && rn_en) begin
                    st   <= FILL;
                    ph_r <= PH_R;
                  end else if (sp_en) begin
                    st   <= SPIN;
                    ph_r <= PH_S;
                    cnt  <= '0;
                  end else begin
                    st   <= IDLE;
                    ph_r <= '0;
                    done <= 1'b1;
                  end
                end
              end
              SPIN: begin
                cnt <= cnt_nx;
                if (cnt_nx == 6'(SPN_U)) begin
                  st   <= IDLE;
                  ph_r <= '0;
                  done <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule
